multicycle_controll: RTL
========================

Name: multicycle_controll

Overview:
Multi-cycle successor to the single-cycle main control decoder. It sequences each RISC-V instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes per state. It waits on a memory ready handshake with a bounded-wait watchdog. It sits between the instruction/data memory port and the shared-ALU datapath.

Parameters:
INSTR_W, 32, instruction width; opcode [6:0], func3 [14:12] and alt bit [30] are fixed positions.
ALU_OP_W, 4, width of ALU_op.
MEM_WAIT_MAX, 15, maximum cycles a memory access may wait for mem_ready before the controller enters ERROR.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
instruction  input  INSTR_W  memory read data; captured at the end of FETCH.
mem_ready  input  1  memory has completed the current access this cycle.
pc_write  output  1  unconditional PC update (PC+4).
pc_write_cond  output  1  branch PC update, qualified by the datapath zero flag.
ir_write  output  1  load the instruction register.
IorD  output  1  0 = address from PC, 1 = address from ALU result.
MemRead  output  1  memory read request.
MemWrite  output  1  memory write request.
MemtoReg  output  1  writeback source: 1 = memory data, 0 = ALU.
ALUScr  output  1  ALU operand B: 1 = immediate, 0 = rs2.
ALU_op  output  ALU_OP_W  ALU operation.
RegWrite  output  1  register file write enable.
branch  output  1  branch compare cycle.
instr_done  output  1  one-cycle pulse when an instruction retires.
error  output  1  sticky; set on watchdog expiry or illegal instruction.

Behaviour:
- Outputs are Moore-decoded from the state register and latched fields (opcode, func3, bit30).
- While reset is high, all outputs are 0. The state loads FETCH, and the wait counter and error are cleared.
- ALU_op encoding: AND=0000, OR=0001, ADD=0010, SUB=0110.
- Decode table:
  - 0x33 R-type: func3 0 gives ADD, or SUB when bit30=1; func3 7 gives AND; func3 6 gives OR.
  - 0x13 I-ALU: func3 0 gives ADD (bit30 ignored); func3 7 gives AND; func3 6 gives OR.
  - 0x03 load and 0x23 store: ADD.
  - 0x63 branch: SUB.
  - Any other opcode, or any other func3 for R/I, is illegal.
- FETCH: MemRead=1, IorD=0. Wait while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, capture the fields, go to DECODE.
- DECODE: one cycle, all strobes 0. Legal → EXEC; illegal → ERROR.
- EXEC: ALU_op is driven. ALUScr=1 for I-ALU, load and store.
  - R/I → WB.
  - load/store → MEM.
  - branch: branch=1, pc_write_cond=1, instr_done=1 → FETCH.
- MEM: IorD=1, ALUScr=1, ALU_op=ADD.
  - load: MemRead=1, wait for mem_ready → WB.
  - store: MemWrite=1, wait for mem_ready, then instr_done=1 → FETCH.
- WB: RegWrite=1, MemtoReg=1 only for load, instr_done=1 → FETCH.
- Zero-wait latencies: branch 3 cycles, R/I and store 4 cycles, load 5 cycles.
- Watchdog: the wait counter is $clog2(MEM_WAIT_MAX+1) bits wide.
  - Cleared on entering FETCH or MEM; increments each cycle in those states with mem_ready=0.
  - When it reaches MEM_WAIT_MAX with mem_ready still 0, go to ERROR.
  - mem_ready in the same cycle the count reaches the limit wins: the access completes normally.
- ERROR: all strobes 0, error=1. Stays in ERROR until reset.
- Reset asserted mid-instruction (any state, including a pending MEM write) aborts it. No strobe is asserted in the reset cycle.

Optional Feature:
- Macro MULTICYCLE_CONTROLL_IMM_ALU_EN.
- Defined: opcode 0x13 is decoded as in the decode table.
- Undefined: 0x13 is illegal and goes DECODE → ERROR. No other behaviour changes.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_R=0x33, OPC_I=0x13, OPC_LOAD=0x03, OPC_STORE=0x23, OPC_BRANCH=0x63);
  - func3 constants;
  - the ALU_op encodings;
  - the state enumeration (FETCH, DECODE, EXEC, MEM, WB, ERROR; 3-bit).
- Sub-module alu_op_decode: combinational; takes opcode, func3 and bit30; returns ALU_op and an illegal flag. It is reused by the single-cycle unit.

Test Plan:
1. R-type, instruction=0x40000033 (SUB), mem_ready always 1 → FETCH, DECODE, EXEC (ALU_op=0110), WB (RegWrite=1, MemtoReg=0). instr_done pulses in cycle 4.
2. Load, opcode 0x03, with 3 wait cycles in MEM → MemRead and IorD=1 held 4 cycles. WB has MemtoReg=1. Total 8 cycles.
3. Store, opcode 0x23, func3 2 → MEM asserts MemWrite=1 and ALUScr=1 with ALU_op=0010. No RegWrite in any cycle. instr_done in cycle 4.
4. Branch, opcode 0x63 → EXEC has ALU_op=0110, branch=1, pc_write_cond=1. Next state is FETCH (3 cycles).
5. Illegal instruction 0x0000007F, and then with mem_ready held 0 for 15 cycles in FETCH → error=1 and all strobes 0 until reset. Also check that mem_ready arriving at count 15 completes normally.
6. Optional feature: instruction 0x00007013 (ANDI) → ALU_op=0000 with ALUScr=1 when the macro is defined; error=1 after DECODE when it is undefined.

Source files
------------

// File: rtl/multicycle_controll_pkg.sv
// Shared constants and state encoding for the multi-cycle control unit and its ALU op decoder.
package multicycle_controll_pkg;

  localparam int unsigned AluOpW = 4;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [AluOpW-1:0] ALU_AND = 4'b0000;
  localparam logic [AluOpW-1:0] ALU_OR  = 4'b0001;
  localparam logic [AluOpW-1:0] ALU_ADD = 4'b0010;
  localparam logic [AluOpW-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StError
  } state_e;

endpackage

// File: rtl/multicycle_controll_alu_op_decode.sv
// Combinational ALU operation decoder shared with the single-cycle control unit.
// I-type ALU ops are legal only when MULTICYCLE_CONTROLL_IMM_ALU_EN is defined.
module multicycle_controll_alu_op_decode
  import multicycle_controll_pkg::*;
(
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        func3_i,
  input  logic              alt_i,
  output logic [AluOpW-1:0] alu_op_o,
  output logic              illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_R: begin
        case (func3_i)
          F3_ADD_SUB: alu_op_o = alt_i ? ALU_SUB : ALU_ADD;
          F3_AND:     alu_op_o = ALU_AND;
          F3_OR:      alu_op_o = ALU_OR;
          default:    illegal_o = 1'b1;
        endcase
      end
`ifdef MULTICYCLE_CONTROLL_IMM_ALU_EN
      // No SUBI exists, so bit30 carries immediate data here and is ignored.
      OPC_I: begin
        case (func3_i)
          F3_ADD_SUB: alu_op_o = ALU_ADD;
          F3_AND:     alu_op_o = ALU_AND;
          F3_OR:      alu_op_o = ALU_OR;
          default:    illegal_o = 1'b1;
        endcase
      end
`endif
      OPC_LOAD, OPC_STORE: alu_op_o = ALU_ADD;
      OPC_BRANCH:          alu_op_o = ALU_SUB;
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controll.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with a memory-wait watchdog.
// Define MULTICYCLE_CONTROLL_IMM_ALU_EN to accept I-type ALU instructions (opcode 0x13).
module multicycle_controll
  import multicycle_controll_pkg::*;
#(
  parameter int unsigned INSTR_W      = 32,
  parameter int unsigned ALU_OP_W     = 4,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                ALUScr,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                RegWrite,
  output logic                branch,
  output logic                instr_done,
  output logic                error
);

  localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        func3_q, func3_d;
  logic              alt_q, alt_d;
  logic              error_q, error_d;
  logic [AluOpW-1:0] dec_alu_op, alu_op;
  logic              dec_illegal;
  logic              wait_expired;
  logic              is_imm, is_load, is_store, is_branch;
  logic              unused_instr;

  assign unused_instr = ^{instruction[INSTR_W-1:31], instruction[29:15], instruction[11:7]};

  multicycle_controll_alu_op_decode u_alu_op_decode (
    .opcode_i  (opcode_q),
    .func3_i   (func3_q),
    .alt_i     (alt_q),
    .alu_op_o  (dec_alu_op),
    .illegal_o (dec_illegal)
  );

  assign is_imm    = (opcode_q == OPC_I);
  assign is_load   = (opcode_q == OPC_LOAD);
  assign is_store  = (opcode_q == OPC_STORE);
  assign is_branch = (opcode_q == OPC_BRANCH);

  // mem_ready on the limit cycle wins over expiry.
  assign wait_expired = !mem_ready && (cnt_q == CntW'(MEM_WAIT_MAX));

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    func3_d       = func3_q;
    alt_d         = alt_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    ALUScr        = 1'b0;
    alu_op        = ALU_AND;
    RegWrite      = 1'b0;
    branch        = 1'b0;
    instr_done    = 1'b0;
    error         = 1'b0;
    // Synchronous reset still has to silence every strobe in its own cycle.
    if (!reset) begin
      error = error_q;
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            opcode_d = instruction[6:0];
            func3_d  = instruction[14:12];
            alt_d    = instruction[30];
            state_d  = StDecode;
          end else if (wait_expired) begin
            state_d = StError;
          end
        end
        StDecode: state_d = dec_illegal ? StError : StExec;
        StExec: begin
          alu_op = dec_alu_op;
          ALUScr = is_imm | is_load | is_store;
          if (is_load || is_store) begin
            state_d = StMem;
          end else if (is_branch) begin
            branch        = 1'b1;
            pc_write_cond = 1'b1;
            instr_done    = 1'b1;
            state_d       = StFetch;
          end else begin
            state_d = StWb;
          end
        end
        StMem: begin
          IorD     = 1'b1;
          ALUScr   = 1'b1;
          alu_op   = ALU_ADD;
          MemRead  = is_load;
          MemWrite = is_store;
          if (mem_ready) begin
            instr_done = is_store;
            state_d    = is_load ? StWb : StFetch;
          end else if (wait_expired) begin
            state_d = StError;
          end
        end
        StWb: begin
          RegWrite   = 1'b1;
          MemtoReg   = is_load;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StError: state_d = StError;
        default: state_d = StError;
      endcase
    end
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q == StFetch || state_q == StMem) && state_d == state_q && !mem_ready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign error_d = error_q | (state_d == StError);
  assign ALU_op  = ALU_OP_W'(alu_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      opcode_q <= '0;
      func3_q  <= '0;
      alt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      opcode_q <= opcode_d;
      func3_q  <= func3_d;
      alt_q    <= alt_d;
    end
  end

endmodule
